// File: rtl/arm_mc_pkg.sv
// Shared definitions for the multicycle ARM controller.
// Contents:
//   state_e  - main FSM state encoding (4 bits, StFetch = 0)
//   SrcB*    - ALUSrcB select constants
//   Res*     - ResultSrc select constants
//   ctrl_t   - packed control word driven by the main FSM output decoder
package arm_mc_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StUnknown  = 4'd10
  } state_e;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// Combinational state -> control word decoder for the main FSM.
// Ports:
//   i_state - current FSM state
//   o_ctrl  - control word; unlisted fields and unknown/illegal states give all zeros
module mainfsm_outdec
  import arm_mc_pkg::*;
(
  input  state_e i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      StFetch: begin
        o_ctrl.ir_write   = 1'b1;
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SrcBFour;
        o_ctrl.result_src = ResAluResult;
        o_ctrl.next_pc    = 1'b1;
      end
      StDecode: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SrcBFour;
        o_ctrl.result_src = ResAluResult;
      end
      StMemAdr: begin
        o_ctrl.alu_src_b = SrcBImm;
      end
      StMemRead: begin
        o_ctrl.adr_src    = 1'b1;
        o_ctrl.result_src = ResAluOut;
      end
      StMemWb: begin
        o_ctrl.result_src = ResData;
        o_ctrl.reg_w      = 1'b1;
      end
      StMemWrite: begin
        o_ctrl.adr_src    = 1'b1;
        o_ctrl.result_src = ResAluOut;
        o_ctrl.mem_w      = 1'b1;
      end
      StExecuteR: begin
        o_ctrl.alu_src_b = SrcBReg;
        o_ctrl.alu_op    = 1'b1;
      end
      StExecuteI: begin
        o_ctrl.alu_src_b = SrcBImm;
        o_ctrl.alu_op    = 1'b1;
      end
      StAluWb: begin
        o_ctrl.result_src = ResAluOut;
        o_ctrl.reg_w      = 1'b1;
      end
      StBranch: begin
        o_ctrl.alu_src_b  = SrcBImm;
        o_ctrl.result_src = ResAluResult;
        o_ctrl.branch     = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Moore main control FSM for the multicycle ARM datapath.
// Sequences fetch/decode/execute/memory/writeback and drives datapath selects plus the raw
// write strobes consumed by condlogic.
// Ports:
//   clk, reset (async, active-low)     - clock and reset
//   Op[1:0], Funct[5:0]                - instruction fields, sampled in DECODE/MEMADR only
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp - datapath controls
//   NextPC, RegW, MemW, Branch         - raw strobes (masked to 0 while in reset)
//   Trap                               - only when MAINFSM_TRAP_EN is defined
// Build option MAINFSM_TRAP_EN: Op=11 enters a sticky UNKNOWN state that raises Trap.
// Without it, Op=11 is a 2-cycle NOP.
module mainfsm
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch
`ifdef MAINFSM_TRAP_EN
  ,
  output logic       Trap
`endif
);

  state_e r_state;
  state_e w_state_next;
  ctrl_t  w_ctrl;

  // Only the I and L bits of Funct steer the sequence.
  logic w_unused_funct;
  assign w_unused_funct = ^Funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = StFetch;
    case (r_state)
      StFetch: w_state_next = StDecode;
      StDecode: begin
        case (Op)
          2'b00:   w_state_next = Funct[5] ? StExecuteI : StExecuteR;
          2'b01:   w_state_next = StMemAdr;
          2'b10:   w_state_next = StBranch;
`ifdef MAINFSM_TRAP_EN
          default: w_state_next = StUnknown;
`else
          default: w_state_next = StFetch;
`endif
        endcase
      end
      StMemAdr:   w_state_next = Funct[0] ? StMemRead : StMemWrite;
      StMemRead:  w_state_next = StMemWb;
      StMemWb:    w_state_next = StFetch;
      StMemWrite: w_state_next = StFetch;
      StExecuteR: w_state_next = StAluWb;
      StExecuteI: w_state_next = StAluWb;
      StAluWb:    w_state_next = StFetch;
      StBranch:   w_state_next = StFetch;
`ifdef MAINFSM_TRAP_EN
      StUnknown:  w_state_next = StUnknown;  // halt until reset
`else
      StUnknown:  w_state_next = StFetch;
`endif
      default:    w_state_next = StFetch;
    endcase
  end

  mainfsm_outdec u_outdec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Selects pass straight through; the reset already parks the state in FETCH.
  assign AdrSrc    = w_ctrl.adr_src;
  assign ALUSrcA   = w_ctrl.alu_src_a;
  assign ALUSrcB   = w_ctrl.alu_src_b;
  assign ResultSrc = w_ctrl.result_src;
  assign ALUOp     = w_ctrl.alu_op;

  // Strobes are gated by reset so nothing writes while reset is low.
  assign IRWrite = w_ctrl.ir_write & reset;
  assign NextPC  = w_ctrl.next_pc & reset;
  assign RegW    = w_ctrl.reg_w & reset;
  assign MemW    = w_ctrl.mem_w & reset;
  assign Branch  = w_ctrl.branch & reset;

`ifdef MAINFSM_TRAP_EN
  assign Trap = (r_state == StUnknown) & reset;
`endif

endmodule
